// File: rtl/mono_stream_arbiter_pkg.sv
// Shared types and helpers for the stream arbiter family.
package mono_stream_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned BURST_W = 8;

    // Channel index width, never below one bit.
    function automatic int unsigned ch_id_w(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/mono_stream_arbiter_rr_pick.sv
// Rotate-find-first: lowest-offset set request at or after start, with wrap.
module mono_stream_arbiter_rr_pick
    import mono_stream_arbiter_pkg::*;
#(
    parameter int unsigned N_CH = 8,
    parameter int unsigned ID_W = ch_id_w(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [ID_W-1:0] start,
    output logic [ID_W-1:0] idx_c,
    output logic            valid_c
);

    logic [2*N_CH-1:0] req_dbl;
    logic [N_CH-1:0]   req_rot;
    int unsigned       sum;

    assign req_dbl = {req, req};
    assign req_rot = N_CH'(req_dbl >> start);

    always_comb begin
        idx_c   = '0;
        valid_c = 1'b0;
        sum     = 0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (!valid_c && req_rot[k]) begin
                valid_c = 1'b1;
                sum     = 32'(start) + k;
                if (sum >= N_CH) begin
                    sum = sum - N_CH;
                end
                idx_c = ID_W'(sum);
            end
        end
    end

endmodule

// File: rtl/mono_stream_arbiter.sv
// Round-robin merge of N_CH FWFT source FIFOs into one stream, with burst limit,
// hold override, optional channel tagging and per-channel word counters.
module mono_stream_arbiter
    import mono_stream_arbiter_pkg::*;
#(
    parameter int unsigned N_CH       = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_MAX  = 4,
    parameter int unsigned TAG_MODE   = 0,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                         BUS_CLK,
    input  logic                         BUS_RST_N,
    input  logic [N_CH-1:0]              CH_EN,
    input  logic [N_CH-1:0]              WRITE_REQ,
    input  logic [N_CH-1:0]              HOLD_REQ,
    input  logic [N_CH*DATA_WIDTH-1:0]   DATA_IN,
    output logic [N_CH-1:0]              READ_GRANT,
    input  logic                         READY_OUT,
    output logic                         WRITE_OUT,
    output logic [DATA_WIDTH-1:0]        DATA_OUT,
    input  logic                         CNT_CLR,
    input  logic [ch_id_w(N_CH)-1:0]     CNT_SEL,
    output logic [CNT_WIDTH-1:0]         CNT_OUT
);

    localparam int unsigned        CH_ID_W   = ch_id_w(N_CH);
    localparam logic [CH_ID_W-1:0] LAST_CH   = CH_ID_W'(N_CH - 1);
    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(BURST_MAX);

    arb_state_e             state_q, state_d;
    logic [CH_ID_W-1:0]     grant_q, grant_d;
    logic [CH_ID_W-1:0]     last_q, last_d;
    logic [BURST_W-1:0]     burst_q, burst_d, burst_inc;
    logic [CH_ID_W-1:0]     start, pick_idx;
    logic                   pick_valid;
    logic                   g_req, g_en, g_hold, xfer;
    logic [DATA_WIDTH-1:0]  g_data;
    logic [CNT_WIDTH-1:0]   cnt_q [N_CH];
    logic [CNT_WIDTH-1:0]   cnt_sel_val;

    assign start = (last_q == LAST_CH) ? '0 : last_q + CH_ID_W'(1);

    mono_stream_arbiter_rr_pick #(
        .N_CH (N_CH),
        .ID_W (CH_ID_W)
    ) u_pick (
        .req     (WRITE_REQ & CH_EN),
        .start   (start),
        .idx_c   (pick_idx),
        .valid_c (pick_valid)
    );

    // Per-channel view of the currently granted source.
    always_comb begin
        g_req  = 1'b0;
        g_en   = 1'b0;
        g_hold = 1'b0;
        g_data = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (grant_q == CH_ID_W'(i)) begin
                g_req  = WRITE_REQ[i];
                g_en   = CH_EN[i];
                g_hold = HOLD_REQ[i];
                g_data = DATA_IN[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= LAST_CH;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    // Next state and transfer outputs; writes only happen while granted.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        burst_d    = burst_q;
        xfer       = 1'b0;
        WRITE_OUT  = 1'b0;
        READ_GRANT = '0;
        DATA_OUT   = '0;
        burst_inc  = (burst_q == '1) ? burst_q : burst_q + BURST_W'(1);
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    burst_d = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                xfer = READY_OUT & g_req & g_en & ((burst_q < BURST_LIM) | g_hold);
                if (xfer) begin
                    WRITE_OUT  = 1'b1;
                    READ_GRANT = N_CH'(1) << grant_q;
                    DATA_OUT   = g_data;
                    if (TAG_MODE != 0) begin
                        DATA_OUT[DATA_WIDTH-1 -: CH_ID_W] = grant_q;
                    end
                    burst_d = burst_inc;
                end
                // A stalled grant whose burst is spent and whose hold dropped also yields.
                if ((!g_req && !g_hold) || !g_en || (!g_hold && (burst_d >= BURST_LIM))) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Saturating word counters; clear wins over a same-cycle increment.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (CNT_CLR) begin
                    cnt_q[i] <= '0;
                end else if (xfer && (grant_q == CH_ID_W'(i)) && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        cnt_sel_val = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (CNT_SEL == CH_ID_W'(i)) begin
                cnt_sel_val = cnt_q[i];
            end
        end
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            CNT_OUT <= '0;
        end else begin
            CNT_OUT <= cnt_sel_val;
        end
    end

endmodule

// File: tb/tb_mono_stream_arbiter.sv
// Directed bench for mono_stream_arbiter: 8 channels, burst 4, tagging on.
module tb_mono_stream_arbiter;

    localparam int unsigned N  = 8;
    localparam int unsigned DW = 32;

    logic          BUS_CLK = 1'b0;
    logic          BUS_RST_N;
    logic [N-1:0]  CH_EN, WRITE_REQ, HOLD_REQ, READ_GRANT;
    logic [N*DW-1:0] DATA_IN;
    logic          READY_OUT, WRITE_OUT, CNT_CLR;
    logic [DW-1:0] DATA_OUT;
    logic [2:0]    CNT_SEL;
    logic [15:0]   CNT_OUT;

    int unsigned seq [N];
    int unsigned exp_seq [N];
    int n_chk = 0;
    int n_err = 0;

    mono_stream_arbiter #(
        .N_CH (8), .DATA_WIDTH (32), .BURST_MAX (4), .TAG_MODE (1), .CNT_WIDTH (16)
    ) dut (
        .BUS_CLK    (BUS_CLK),
        .BUS_RST_N  (BUS_RST_N),
        .CH_EN      (CH_EN),
        .WRITE_REQ  (WRITE_REQ),
        .HOLD_REQ   (HOLD_REQ),
        .DATA_IN    (DATA_IN),
        .READ_GRANT (READ_GRANT),
        .READY_OUT  (READY_OUT),
        .WRITE_OUT  (WRITE_OUT),
        .DATA_OUT   (DATA_OUT),
        .CNT_CLR    (CNT_CLR),
        .CNT_SEL    (CNT_SEL),
        .CNT_OUT    (CNT_OUT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < N; i++) begin
            DATA_IN[i*DW +: DW] = {3'b111, 5'(i), 24'(seq[i])};
        end
    endtask

    // One clock: pops seen just before the edge advance the source FIFOs.
    task automatic cycle();
        logic [N-1:0] pend;
        #1;
        pend = READ_GRANT;
        @(posedge BUS_CLK);
        #1;
        for (int i = 0; i < N; i++) begin
            if (pend[i]) seq[i]++;
        end
        drive_data();
        #1;
    endtask

    task automatic expect_word(input int ch, input bit commit);
        logic [31:0] exp_d;
        exp_d = {3'(ch), 5'(ch), 24'(exp_seq[ch])};
        check_eq($sformatf("wr ch%0d", ch), 32'(WRITE_OUT), 32'd1);
        check_eq($sformatf("grant ch%0d", ch), 32'(READ_GRANT), 32'd1 << ch);
        check_eq($sformatf("data ch%0d", ch), DATA_OUT, exp_d);
        if (commit) exp_seq[ch]++;
    endtask

    task automatic expect_idle(input string tag);
        check_eq({tag, " wr"}, 32'(WRITE_OUT), 32'd0);
        check_eq({tag, " grant"}, 32'(READ_GRANT), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int order [7];
        int nwords;
        logic [31:0] last_exp;
        order = '{4, 5, 6, 7, 0, 1, 3};
        for (int i = 0; i < N; i++) begin
            seq[i] = 0;
            exp_seq[i] = 0;
        end
        BUS_RST_N = 1'b0;
        CH_EN     = 8'hFF;
        WRITE_REQ = 8'hFF;
        HOLD_REQ  = 8'h00;
        READY_OUT = 1'b1;
        CNT_CLR   = 1'b0;
        CNT_SEL   = 3'd0;
        drive_data();

        // Reset held with every channel requesting.
        for (int i = 0; i < 3; i++) begin
            cycle();
            expect_idle("reset");
            check_eq("reset cnt", 32'(CNT_OUT), 32'd0);
        end
        BUS_RST_N = 1'b1;
        #1;
        expect_idle("post-reset");
        check_eq("post-reset cnt", 32'(CNT_OUT), 32'd0);

        // Strict rotation, 4 words then one switch cycle per channel.
        for (int r = 0; r < 2; r++) begin
            for (int ch = 0; ch < N; ch++) begin
                for (int k = 0; k < 4; k++) begin
                    cycle();
                    expect_word(ch, 1'b1);
                end
                cycle();
                expect_idle("switch");
            end
        end
        WRITE_REQ = 8'h00;
        CNT_SEL = 3'd0;
        cycle();
        check_eq("cnt ch0 rot", 32'(CNT_OUT), 32'(exp_seq[0]));
        CNT_SEL = 3'd7;
        cycle();
        check_eq("cnt ch7 rot", 32'(CNT_OUT), 32'(exp_seq[7]));

        // Backpressure mid-burst on ch3.
        WRITE_REQ = 8'h08;
        cycle(); expect_word(3, 1'b1);
        cycle(); expect_word(3, 1'b1);
        cycle(); expect_word(3, 1'b0);
        READY_OUT = 1'b0;
        WRITE_REQ = 8'hFF;
        #1; expect_idle("bp gated");
        for (int i = 0; i < 5; i++) begin
            cycle();
            expect_idle("bp stall");
        end
        READY_OUT = 1'b1;
        #1; expect_word(3, 1'b1);
        cycle(); expect_word(3, 1'b1);
        cycle(); expect_idle("bp release");
        cycle(); expect_word(4, 1'b0);
        WRITE_REQ = 8'h00;
        cycle(); expect_idle("bp end");

        // HOLD keeps ch2 beyond the burst limit and across an empty gap.
        WRITE_REQ = 8'h04;
        HOLD_REQ  = 8'h04;
        cycle(); expect_word(2, 1'b1);
        WRITE_REQ = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            cycle(); expect_word(2, 1'b1);
        end
        cycle(); expect_word(2, 1'b0);
        WRITE_REQ = 8'hFB;
        #1; expect_idle("hold gap");
        for (int i = 0; i < 3; i++) begin
            cycle(); expect_idle("hold gap");
        end
        WRITE_REQ = 8'hFF;
        #1; expect_word(2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(); expect_word(2, 1'b1);
        end
        cycle();
        HOLD_REQ = 8'h00;
        #1; expect_idle("hold drop");
        cycle(); expect_idle("hold leave");
        cycle(); expect_word(3, 1'b0);
        WRITE_REQ = 8'h00;
        cycle(); expect_idle("hold end");

        // Channel 2 disabled; tag shows the granted channel.
        CH_EN = 8'hFB;
        WRITE_REQ = 8'hFF;
        for (int j = 0; j < 7; j++) begin
            for (int k = 0; k < 4; k++) begin
                cycle();
                expect_word(order[j], 1'b1);
            end
            cycle();
            expect_idle("en switch");
        end
        cycle(); expect_word(4, 1'b0);
        CH_EN = 8'hEB;
        #1; expect_idle("en drop");
        cycle(); expect_idle("en leave");
        cycle(); expect_word(5, 1'b0);
        WRITE_REQ = 8'h00;
        cycle(); expect_idle("en end");

        CH_EN = 8'hFF;
        for (int ch = 0; ch < N; ch++) begin
            CNT_SEL = 3'(ch);
            cycle();
            check_eq($sformatf("cnt ch%0d", ch), 32'(CNT_OUT), 32'(exp_seq[ch]));
        end

        // Long held stream on ch5 saturates its counter.
        WRITE_REQ = 8'h20;
        HOLD_REQ  = 8'h20;
        CNT_SEL   = 3'd5;
        nwords = 0;
        for (int i = 0; i < 70000; i++) begin
            cycle();
            if (WRITE_OUT && READ_GRANT == 8'h20) nwords++;
        end
        check_eq("long words", 32'(nwords), 32'd70000);
        last_exp = {3'd5, 5'd5, 24'(exp_seq[5] + 69999)};
        check_eq("long last data", DATA_OUT, last_exp);
        exp_seq[5] = exp_seq[5] + 69999;
        WRITE_REQ = 8'h00;
        HOLD_REQ  = 8'h00;
        cycle();
        check_eq("cnt sat", 32'(CNT_OUT), 32'h0000_FFFF);

        // Clear coincident with a transfer.
        WRITE_REQ = 8'h20;
        cycle(); expect_word(5, 1'b1);
        CNT_CLR = 1'b1;
        cycle();
        CNT_CLR = 1'b0;
        WRITE_REQ = 8'h00;
        cycle();
        check_eq("cnt clr ch5", 32'(CNT_OUT), 32'd0);
        CNT_SEL = 3'd2;
        cycle();
        check_eq("cnt clr ch2", 32'(CNT_OUT), 32'd0);
        expect_idle("final");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
